// File: rtl/ddr_deser_stream.sv
// DDR input capture and deserializer: samples din on both clock edges, packs RATIO
// rise/fall pairs into one word and hands words out through a 2-entry FWFT buffer.
module ddr_deser_stream #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned RATIO      = 2,
    parameter bit          RISE_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          din_en,
    output logic [2*DATA_WIDTH*RATIO-1:0] dout,
    output logic                          dout_vld,
    input  logic                          dout_rd,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned WW = PW * RATIO;

    logic [DATA_WIDTH-1:0] r_rise;
    logic [DATA_WIDTH-1:0] r_fall;
    logic                  en_q;
    logic [PW-1:0]         pair;
    logic                  last_beat;
    logic [WW-1:0]         word;
    logic                  push;

    logic [WW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;

    // Rise sample and its enable are taken together on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            en_q   <= 1'b0;
        end else begin
            r_rise <= din;
            en_q   <= din_en;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fall <= '0;
        end else begin
            r_fall <= din;
        end
    end

    assign pair = RISE_FIRST ? {r_fall, r_rise} : {r_rise, r_fall};

    generate
        if (RATIO == 1) begin : g_single
            assign last_beat = 1'b1;
            assign word      = pair;
        end else begin : g_multi
            localparam int unsigned CW = $clog2(RATIO);

            logic [CW-1:0]             beat_cnt;
            logic [PW*(RATIO-1)-1:0]   acc;

            assign last_beat = (beat_cnt == CW'(RATIO - 1));
            // The final pair bypasses the accumulator and lands in the top slot.
            assign word      = {pair, acc};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    beat_cnt <= '0;
                    acc      <= '0;
                end else if (en_q) begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                        for (int unsigned i = 0; i < RATIO - 1; i++) begin
                            if (beat_cnt == CW'(i)) begin
                                acc[i*PW +: PW] <= pair;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    assign push  = en_q && last_beat;
    assign full  = (count == 2'd2);
    assign pop   = (count != 2'd0) && dout_rd;
    // A pop frees the head slot in the same edge, so full+pop still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, pop};
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign dout     = mem[rd_ptr];
    assign dout_vld = (count != 2'd0);

endmodule

// File: doc/ddr_deser_stream.md
Name: ddr_deser_stream

Overview:
Parametrised DDR input capture and deserializer. It samples a DATA_WIDTH-bit bus on both edges of clk and gathers RATIO rise/fall pairs into one wide word. Words are delivered through a 2-entry valid/ready output buffer. The block sits at the interface boundary, between a DDR source (pad side) and single-rate stream logic in the clk domain.

Parameters:
DATA_WIDTH, 1, bits of the DDR bus sampled per edge
RATIO, 2, rise/fall pairs per output word (>=1)
RISE_FIRST, 1, 1: rise sample occupies the lower DATA_WIDTH bits of each pair; 0: fall sample occupies them

Ports:
clk  in  1  single clock; both edges are used for capture
rst_n  in  1  asynchronous reset, active-low
din  in  DATA_WIDTH  DDR data bus
din_en  in  1  capture enable, sampled at posedge together with the rise sample
dout  out  2*DATA_WIDTH*RATIO  assembled word; pair 0 in the LSBs
dout_vld  out  1  word available
dout_rd  in  1  consumer accepts dout when dout_vld && dout_rd at posedge
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf at posedge

Behaviour:
- Reset (rst_n=0, asynchronous, including the negedge register) clears:
  - capture regs r_rise, r_fall, en_q
  - beat_cnt, accumulator, FIFO pointers and count
  - dout=0, dout_vld=0, ovf=0
  - Reset release takes effect at the next posedge.
- Capture:
  - posedge: r_rise<=din, en_q<=din_en.
  - negedge: r_fall<=din.
- Pair formation:
  - At posedge k, pair = {r_rise from posedge k-1, r_fall from the intervening negedge}.
  - Ordering follows RISE_FIRST.
  - The pair is valid only if en_q=1; pairs with en_q=0 are discarded and beat_cnt holds.
- Assembly:
  - Each valid pair is written at slot beat_cnt of the accumulator; beat_cnt increments.
  - When beat_cnt==RATIO-1 and a valid pair arrives, the word {pair, acc slots 0..RATIO-2} is pushed at that same posedge and beat_cnt wraps to 0.
  - RATIO=1: every valid pair is a word.
- Latency: a rise sample taken at posedge k with din_en=1 completes a word at posedge k+1 (RATIO=1). dout_vld rises right after posedge k+1.
- Output FIFO:
  - Depth 2, first-word fall-through; dout always reflects the head entry.
  - dout_vld = (count != 0).
  - Pop occurs on dout_vld && dout_rd.
  - Push and pop in the same cycle: count unchanged, order preserved. A push while full combined with a pop is allowed and does not overflow.
  - Push while full without pop: the new word is dropped, ovf<=1, FIFO contents untouched.
  - dout_rd while empty: ignored.
- ovf:
  - Sticky until ovf_clr=1 at a posedge.
  - If a drop and ovf_clr occur at the same edge, set wins (ovf stays 1).
- Partial word: a din_en gap does not reset beat_cnt; assembly resumes at the next valid pair.
- Reset mid-word: the partial accumulator and all buffered words are lost.
- Widths:
  - beat_cnt is clog2(RATIO) bits, minimum 1.
  - No arithmetic on data; bits are only concatenated.

Test Plan:
1. DATA_WIDTH=4, RATIO=1, RISE_FIRST=1, dout_rd=1; din=0x3 at posedge and 0xA at negedge with en=1 -> dout=0xA3, dout_vld high for one cycle right after the next posedge.
2. RATIO=2, pairs (rise,fall) = (1,2),(3,4) -> one word dout=0x4321. With RISE_FIRST=0 the same stimulus -> dout=0x3412.
3. RATIO=2, din_en low for 3 cycles between the two pairs -> still exactly one word, 0x4321, with no spurious vld.
4. dout_rd=0, feed 3 words 0x11,0x22,0x33 (RATIO=1) -> FIFO holds 0x11,0x22 and ovf=1. Raise dout_rd -> 0x11 then 0x22, then vld=0. Pulse ovf_clr -> ovf=0.
5. FIFO full with dout_rd=1 at the same edge as a new push -> no overflow, and the output order is preserved.
6. Drive rst_n low between clock edges mid-word (after pair 0 of RATIO=2) -> outputs clear immediately. After release, the next two pairs form a complete word, with no residue from before reset.
